aes_key_sched_ctrl: RTL and testbench
=====================================

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 SHALL have parameter NK, default 8, meaning the cipher key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a key expansion of key_in.
REQ-005 SHALL have port key_in, input, 256 bits: cipher key, word 0 in bits [255:224]; bits below word NK-1 ignored.
REQ-006 SHALL have port busy, output, 1 bit: expansion in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when expansion completes.
REQ-008 SHALL have port key_ready, output, 1 bit: the schedule buffer holds a complete schedule.
REQ-009 SHALL have port rk_idx, input, 4 bits: round-key select.
REQ-010 SHALL have port rk_out, output, 128 bits: round key rk_idx, taken as words 4*rk_idx..4*rk_idx+3, with the lowest-numbered word in [127:96].
REQ-011 SHALL have port rk_valid, output, 1 bit: key_ready AND rk_idx <= NR.

Function
REQ-012 SHALL derive NR = 10/12/14 and NSTEPS = 10/8/7 for NK = 4/6/8.
REQ-013 SHALL hold a 60 x 32-bit word buffer w[0..59].
REQ-014 SHALL compute one step per cycle: from the previous NK words and round index r, produce the next NK words per FIPS-197 key expansion.
REQ-015 Step rules: RotWord/SubWord/Rcon(r) applied to the first new word; for NK=8, the extra SubWord applied to new word 4.
REQ-016 Rcon(r) SHALL be 01,02,04,08,10,20,40,80,1B,36 in the top byte, for r = 1..10.
REQ-017 SHALL use FSM states IDLE, EXPAND and DONE.
REQ-018 In IDLE or DONE with start=1: write key words to w[0..NK-1], set r=1, clear key_ready, go to EXPAND.
REQ-019 In EXPAND, each cycle: write step r results to w[NK*r .. NK*r+NK-1], dropping indices above 4*NR+3, then increment r.
REQ-020 When the step with r=NSTEPS is written: go to DONE, assert done for one cycle, and set key_ready.
REQ-021 key_ready SHALL first be high NSTEPS+1 cycles after the edge sampling start (11/9/8 cycles for NK = 4/6/8).
REQ-022 busy SHALL equal (state == EXPAND).
REQ-023 start SHALL be ignored while in EXPAND.
REQ-024 Restart from DONE SHALL be immediately legal, with key_ready dropping on the next cycle.
REQ-025 rk_out SHALL be a combinational read; when rk_valid=0, rk_out SHALL be all zeros.
REQ-026 Buffer words SHALL be written only in the cycles stated in REQ-018 and REQ-019.

Reset
REQ-027 When rst_n=0 at a clock edge: state=IDLE, r=0, busy=0, done=0, key_ready=0, and all buffer words cleared to zero.
REQ-028 Reset mid-EXPAND SHALL abandon the expansion, with no done pulse.
REQ-029 rst_n SHALL have priority over start, and over zeroize when present.

Configuration
REQ-030 With macro AES_KEY_SCHED_ZEROIZE_EN defined: add a 1-bit input zeroize.
REQ-031 zeroize=1 in any state SHALL, at the next edge, clear all buffer words, set key_ready=0 and done=0, go to IDLE, and take priority over start.
REQ-032 Without AES_KEY_SCHED_ZEROIZE_EN: the zeroize port and its logic SHALL be absent, and buffer contents SHALL persist until reset or overwrite.

Verification
REQ-033 NK=4, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, start pulse -> key_ready after 11 cycles; rk_idx=10 gives d014f9a8 c9ee2589 e13f0cc8 b6630ca6; rk_idx=1 gives a0fafe17 88542cb1 23a33939 2a6c7605.
REQ-034 NK=6, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> key_ready after 9 cycles; rk_idx=12 gives e98ba06f 448c773c 8ecc7204 01002202.
REQ-035 NK=8, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> key_ready after 8 cycles; rk_idx=14 gives fe4890d1 e6188d0b 046df344 706c631e; rk_idx=15 gives rk_valid=0 and rk_out=0.
REQ-036 start with a different key re-pulsed during EXPAND -> ignored; the schedule matches the first key; exactly one done pulse.
REQ-037 rst_n=0 during cycle 3 of EXPAND -> next cycle busy=0, key_ready=0, rk_out=0 for all rk_idx, and no done pulse.
REQ-038 With AES_KEY_SCHED_ZEROIZE_EN defined, zeroize=1 and start=1 together in DONE -> IDLE, key_ready=0, rk_out=0, and no expansion starts.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: iterative AES-128/192/256 key expansion into a 60-word round-key buffer
// Ports: clk, rst_n (sync, active-low), start, key_in[255:0] (word 0 in [255:224]),
//        rk_idx[3:0] -> rk_out[127:0] / rk_valid (combinational read), busy, done (pulse), key_ready.
// Optional: define AES_KEY_SCHED_ZEROIZE_EN to add input zeroize (wipes buffer, returns to IDLE).
module aes_key_sched_ctrl #(
    parameter int NK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic [255:0] key_in,
    input  logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic         key_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out
);
    localparam int NR = NK == 4 ? 10 : NK == 6 ? 12 : 14;
    localparam int NSTEPS = NK == 4 ? 10 : NK == 6 ? 8 : 7;
    localparam logic [5:0] LAST = 6'(4 * NR + 3);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_round;
    logic        r_done, r_key_ready;
    logic [31:0] r_w [60];
    logic [31:0] r_win [8];
    logic [31:0] w_new [8];
    logic        w_zero, w_load, w_step, w_last;
    logic [5:0]  w_base, w_rb;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the FIPS-197 affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s, v;
        s = a;
        v = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            v = gmul(v, s);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        return r == 4'd9 ? 8'h1b : r == 4'd10 ? 8'h36 : 8'h01 << (r - 4'd1);
    endfunction

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    assign w_zero = zeroize;
`else
    assign w_zero = 1'b0;
`endif

    assign w_load = !w_zero && start && r_state != EXPAND;
    assign w_step = !w_zero && r_state == EXPAND;
    assign w_last = r_round == 4'(NSTEPS);
    assign w_base = 6'(NK) * 6'(r_round);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_zero) w_next = IDLE;
        else if (w_load) w_next = EXPAND;
        else if (w_step && w_last) w_next = DONE;
    end

    // One full step: the NK words following the current window
    always_comb begin
        logic [31:0] w_t;
        w_new = '{default: '0};
        w_t = r_win[0] ^ sub_word({r_win[NK-1][23:0], r_win[NK-1][31:24]}) ^ {rcon(r_round), 24'h0};
        w_new[0] = w_t;
        for (int j = 1; j < NK; j++) begin
            w_t = r_win[j] ^ ((NK == 8 && j == 4) ? sub_word(w_t) : w_t);
            w_new[j] = w_t;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_zero) begin
            r_round     <= '0;
            r_done      <= 1'b0;
            r_key_ready <= 1'b0;
            r_win       <= '{default: '0};
            r_w         <= '{default: '0};
        end else begin
            r_done <= w_step && w_last;
            if (w_load) begin
                r_round     <= 4'd1;
                r_key_ready <= 1'b0;
                for (int j = 0; j < NK; j++) begin
                    r_w[j]   <= key_in[255 - 32*j -: 32];
                    r_win[j] <= key_in[255 - 32*j -: 32];
                end
            end else if (w_step) begin
                r_round <= r_round + 4'd1;
                r_win   <= w_new;
                if (w_last) r_key_ready <= 1'b1;
                // the final step may overrun the schedule; those words are discarded
                for (int j = 0; j < NK; j++)
                    if (w_base + 6'(j) <= LAST) r_w[w_base + 6'(j)] <= w_new[j];
            end
        end
    end

    assign busy      = r_state == EXPAND;
    assign done      = r_done;
    assign key_ready = r_key_ready;
    assign rk_valid  = r_key_ready && rk_idx <= 4'(NR);
    assign w_rb      = rk_valid ? {rk_idx, 2'b00} : 6'd0;
    assign rk_out    = rk_valid ? {r_w[w_rb], r_w[w_rb + 6'd1], r_w[w_rb + 6'd2], r_w[w_rb + 6'd3]} : '0;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: scoreboard bench for NK=4/6/8 instances against a table-driven FIPS-197 model
module tb_aes_key_sched_ctrl;
    logic         clk = 1'b0;
    logic         rst_n, start, stim_own;
    logic [255:0] key_in;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    logic         zeroize;
`endif
    logic [3:0]    rk_idx_a [3];
    logic [3:0]    stim_idx [3];
    logic          busy_a [3], done_a [3], kr_a [3], rkv_a [3];
    logic [127:0]  rko_a [3];
    logic [1919:0] exp_q [3][$];
    int tests = 0, fails = 0, cyc = 0, start_cyc = 0;

    logic [2047:0] sbox_tab = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;
    logic [7:0] rcon_tab [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nk_of(input int d);
        return d == 0 ? 4 : d == 1 ? 6 : 8;
    endfunction

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int ns_of(input int nk);
        return (4 * (nk + 7) + nk - 1) / nk - 1;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        logic [31:0] y;
        for (int b = 0; b < 4; b++) y[8*b +: 8] = sbox_tab[2047 - 8*int'(x[8*b +: 8]) -: 8];
        return y;
    endfunction

    function automatic logic [1919:0] expand(input int nk, input logic [255:0] k);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [1919:0] res;
        for (int i = 0; i < 60; i++) w[i] = (i < nk) ? k[255 - 32*i -: 32] : 32'h0;
        for (int i = nk; i < 4 * (nr_of(nk) + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk], 24'h0};
            else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 60; i++) res[1919 - 32*i -: 32] = w[i];
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gd
        localparam int NKG = g == 0 ? 4 : g == 1 ? 6 : 8;
        logic [3:0] mi = '0;
        int nd = 0;
        assign rk_idx_a[g] = stim_own ? stim_idx[g] : mi;
        aes_key_sched_ctrl #(.NK(NKG)) dut (
            .clk(clk), .rst_n(rst_n), .start(start),
`ifdef AES_KEY_SCHED_ZEROIZE_EN
            .zeroize(zeroize),
`endif
            .key_in(key_in), .rk_idx(rk_idx_a[g]), .busy(busy_a[g]), .done(done_a[g]),
            .key_ready(kr_a[g]), .rk_valid(rkv_a[g]), .rk_out(rko_a[g]));

        initial begin : mon
            logic [1919:0] e;
            logic [127:0]  x;
            forever begin
                @(negedge clk);
                if (done_a[g] === 1'b1) begin
                    nd++;
                    if (exp_q[g].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL nk%0d unexpected done", NKG);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("nk%0d latency", NKG), 128'(cyc - start_cyc), 128'(ns_of(NKG) + 1));
                        chk($sformatf("nk%0d key_ready at done", NKG), 128'(kr_a[g]), 128'd1);
                        chk($sformatf("nk%0d busy at done", NKG), 128'(busy_a[g]), 128'd0);
                        for (int i = 0; i < 16; i++) begin
                            mi = 4'(i);
                            #1;
                            x = (i <= nr_of(NKG)) ? e[1919 - 128*(i <= 14 ? i : 0) -: 128] : 128'h0;
                            chk($sformatf("nk%0d rk_valid[%0d]", NKG, i), 128'(rkv_a[g]), 128'(i <= nr_of(NKG)));
                            chk($sformatf("nk%0d rk_out[%0d]", NKG, i), rko_a[g], x);
                        end
                    end
                end
            end
        end
    end

    function automatic int nd_of(input int d);
        return d == 0 ? gd[0].nd : d == 1 ? gd[1].nd : gd[2].nd;
    endfunction

    task automatic run(input logic [255:0] k, input bit repulse);
        int snap [3];
        for (int d = 0; d < 3; d++) begin
            snap[d] = nd_of(d);
            exp_q[d].push_back(expand(nk_of(d), k));
        end
        key_in = k;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("nk%0d busy after start", nk_of(d)), 128'(busy_a[d]), 128'd1);
            chk($sformatf("nk%0d key_ready drop", nk_of(d)), 128'(kr_a[d]), 128'd0);
        end
        if (repulse) begin
            @(negedge clk);
            key_in = ~k;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (28) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("nk%0d pending schedules", nk_of(d)), 128'(exp_q[d].size()), 128'd0);
            chk($sformatf("nk%0d done pulses", nk_of(d)), 128'(nd_of(d) - snap[d]), 128'd1);
            exp_q[d].delete();
        end
    endtask

    task automatic kat(input int d, input logic [3:0] idx, input logic [127:0] v, input logic vv);
        stim_own = 1'b1;
        stim_idx[d] = idx;
        #1;
        chk($sformatf("nk%0d kat rk_out[%0d]", nk_of(d), idx), rko_a[d], v);
        chk($sformatf("nk%0d kat rk_valid[%0d]", nk_of(d), idx), 128'(rkv_a[d]), 128'(vv));
        stim_own = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        stim_own = 1'b1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s nk%0d busy", tag, nk_of(d)), 128'(busy_a[d]), 128'd0);
            chk($sformatf("%s nk%0d done", tag, nk_of(d)), 128'(done_a[d]), 128'd0);
            chk($sformatf("%s nk%0d key_ready", tag, nk_of(d)), 128'(kr_a[d]), 128'd0);
        end
        for (int i = 0; i < 16; i++) begin
            stim_idx = '{default: 4'(i)};
            #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("%s nk%0d rk_valid[%0d]", tag, nk_of(d), i), 128'(rkv_a[d]), 128'd0);
                chk($sformatf("%s nk%0d rk_out[%0d]", tag, nk_of(d), i), rko_a[d], 128'h0);
            end
        end
        stim_own = 1'b0;
    endtask

    initial begin
        int snap [3];
        rst_n = 1'b0;
        start = 1'b0;
        key_in = '0;
        stim_own = 1'b1;
        stim_idx = '{default: '0};
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0);
        kat(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
        kat(0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
        run({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 1'b0);
        kat(1, 4'd12, 128'he98ba06f448c773c8ecc720401002202, 1'b1);
        run(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b0);
        kat(2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1);
        kat(2, 4'd15, 128'h0, 1'b0);
        repeat (5) run({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
        run({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);

        for (int d = 0; d < 3; d++) snap[d] = nd_of(d);
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared("mid reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("nk%0d no done after reset", nk_of(d)), 128'(nd_of(d) - snap[d]), 128'd0);

        run({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        for (int d = 0; d < 3; d++) snap[d] = nd_of(d);
        zeroize = 1'b1;
        start = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        start = 1'b0;
        check_cleared("zeroize");
        repeat (15) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("nk%0d idle after zeroize", nk_of(d)), 128'(busy_a[d]), 128'd0);
            chk($sformatf("nk%0d no done after zeroize", nk_of(d)), 128'(nd_of(d) - snap[d]), 128'd0);
        end
        run({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
